// File: rtl/prng_pkg.sv
// Shared types, default tap/seed constants and the LFSR step for the PRNG stream block.
package prng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_OUT   = 2'b10
  } prng_state_e;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [7:0]  SEED_W8  = 8'h01;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [15:0] SEED_W16 = 16'hACE1;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;
  localparam logic [31:0] SEED_W32 = 32'h02468ACD;

  localparam int MAX_W = 64;

  // Operands are zero-extended to MAX_W; truncating the result to W gives
  // {lfsr[W-2:0], ^(lfsr & taps)} for any W <= MAX_W.
  function automatic logic [MAX_W-1:0] next_lfsr(input logic [MAX_W-1:0] lfsr,
                                                 input logic [MAX_W-1:0] taps);
    return {lfsr[MAX_W-2:0], ^(lfsr & taps)};
  endfunction

endpackage

// File: rtl/prng_lfsr_w.sv
// W-bit Fibonacci LFSR register with seed load (zero replaced by SEED) and shift enable.
module prng_lfsr_w
  import prng_pkg::*;
#(
  parameter int             W    = 32,
  parameter logic [W-1:0]   TAPS = TAPS_W32,
  parameter logic [W-1:0]   SEED = SEED_W32
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_en_i,
  output logic [W-1:0] lfsr_o
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;
  logic [W-1:0] lfsr_step;

  assign lfsr_step = W'(next_lfsr(MAX_W'(lfsr_q), MAX_W'(TAPS)));

  // Load wins over shift; a zero seed would lock the LFSR, so it becomes SEED.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (load_val_i == '0) ? SEED : load_val_i;
    end else if (shift_en_i) begin
      lfsr_d = lfsr_step;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/prng_stream.sv
// On request, steps the LFSR SHIFT_CYC times, then streams the word LSB chunk first over valid/ready.
module prng_stream
  import prng_pkg::*;
#(
  parameter int           W         = 32,
  parameter int           OW        = 8,
  parameter logic [W-1:0] TAPS      = TAPS_W32,
  parameter logic [W-1:0] SEED      = SEED_W32,
  parameter int           SHIFT_CYC = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          seed_load,
  input  logic [W-1:0]  seed_in,
  input  logic          get_random,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [OW-1:0] data_out,
  output logic          busy
);

  localparam int         NCHUNK     = W / OW;
  localparam int         CW         = $clog2(NCHUNK);
  localparam logic [7:0] SHIFT_LAST = 8'(SHIFT_CYC - 1);
  localparam logic [CW-1:0] CHUNK_LAST = CW'(NCHUNK - 1);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_valid never drops and data_out never changes until that beat transfers.

  prng_state_e   state_q;
  logic [7:0]    shift_cnt_q;
  logic [CW-1:0] chunk_cnt_q;
  logic [CW-1:0] chunk_cnt_d;
  logic          out_valid_q;
  logic          busy_q;
  logic [W-1:0]  lfsr;
  logic          lfsr_load;
  logic          lfsr_shift;

  function automatic logic [OW-1:0] chunk_of(input logic [W-1:0] v, input logic [CW-1:0] idx);
    return v[int'(idx) * OW +: OW];
  endfunction

  assign lfsr_load   = (state_q == ST_IDLE) && seed_load;
  assign lfsr_shift  = (state_q == ST_SHIFT);
  assign chunk_cnt_d = chunk_cnt_q + CW'(1);

  prng_lfsr_w #(
    .W    (W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .load_i     (lfsr_load),
    .load_val_i (seed_in),
    .shift_en_i (lfsr_shift),
    .lfsr_o     (lfsr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      chunk_cnt_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A seed load in the same cycle swallows the request.
          if (get_random && !seed_load) begin
            state_q     <= ST_SHIFT;
            shift_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          shift_cnt_q <= shift_cnt_q + 8'd1;
          if (shift_cnt_q == SHIFT_LAST) begin
            state_q     <= ST_OUT;
            chunk_cnt_q <= '0;
            out_valid_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (chunk_cnt_q == CHUNK_LAST) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              chunk_cnt_q <= chunk_cnt_d;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign data_out  = out_valid_q ? chunk_of(lfsr, chunk_cnt_q) : '0;

endmodule

// File: tb/tb_prng_stream.sv
// Directed bench for prng_stream: an 8-bit instance for the small hand case, a default 32-bit instance for the rest.
module tb_prng_stream;

  localparam logic [31:0] SEED32 = 32'h02468ACD;
  localparam logic [31:0] TAPS32 = 32'h80200003;

  logic clk;
  logic rstn;

  // 8-bit instance
  logic       g8, sl8, rd8;
  logic [7:0] si8;
  logic       v8, b8;
  logic [3:0] d8;

  // 32-bit instance
  logic        r_get, r_seed_load, r_ready;
  logic [31:0] r_seed_in;
  logic        v32, b32;
  logic [7:0]  d32;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  prng_stream #(
    .W(8), .OW(4), .TAPS(8'hB8), .SEED(8'h01), .SHIFT_CYC(1)
  ) u8 (
    .clk(clk), .rstn(rstn), .seed_load(sl8), .seed_in(si8), .get_random(g8),
    .out_ready(rd8), .out_valid(v8), .data_out(d8), .busy(b8)
  );

  prng_stream u32 (
    .clk(clk), .rstn(rstn), .seed_load(r_seed_load), .seed_in(r_seed_in),
    .get_random(r_get), .out_ready(r_ready), .out_valid(v32), .data_out(d32), .busy(b32)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model32(input logic [31:0] s, input int n);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[30:0], ^(v & TAPS32)};
    return v;
  endfunction

  task automatic push_word(input logic [31:0] w);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i*8 +: 8]);
  endtask

  // Called just after a negedge with the 32-bit DUT idle; returns cycles until out_valid.
  task automatic request32(input bit inj, output int lat);
    r_get = 1'b1;
    lat   = 0;
    @(negedge clk);
    lat = 1;
    while (!v32 && lat < 200) begin
      r_get       = inj && (lat == 5);
      r_seed_load = inj && (lat == 5);
      r_seed_in   = 32'hCAFEF00D;
      @(negedge clk);
      lat++;
    end
    r_get       = 1'b0;
    r_seed_load = 1'b0;
  endtask

  // Drains one word; optional stall on beat stall_idx and request/seed pulses on beat inj_idx.
  task automatic collect32(input int stall_idx, input int inj_idx,
                           output logic [31:0] word, output int nbeats);
    logic [7:0] beat;
    word   = '0;
    nbeats = 0;
    for (int cyc = 0; cyc < 64 && v32; cyc++) begin
      beat = d32;
      if (exp_q.size() > 0) check("beat", 32'(beat), 32'(exp_q.pop_front()));
      if (nbeats < 4) word[nbeats*8 +: 8] = beat;
      r_get       = (nbeats == inj_idx);
      r_seed_load = (nbeats == inj_idx);
      r_seed_in   = 32'h12345678;
      if (nbeats == stall_idx) begin
        r_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          r_get       = 1'b0;
          r_seed_load = 1'b0;
          check("stall_valid", 32'(v32), 1);
          check("stall_data", 32'(d32), 32'(beat));
        end
        r_ready = 1'b1;
      end
      nbeats++;
      @(negedge clk);
      r_get       = 1'b0;
      r_seed_load = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] w_ref, w, w_exp;
    int lat, nb;

    g8 = 0; sl8 = 0; si8 = '0; rd8 = 1;
    r_get = 0; r_seed_load = 0; r_seed_in = '0; r_ready = 1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(v32), 0);
    check("rst_data", 32'(d32), 0);
    check("rst_busy", 32'(b32), 0);
    check("rst_lfsr", u32.u_lfsr.lfsr_q, SEED32);
    check("rst_lfsr8", 32'(u8.u_lfsr.lfsr_q), 32'h01);
    rstn = 1'b1;
    @(negedge clk);

    // small instance, single step, two nibble beats
    g8 = 1'b1;
    @(negedge clk);
    g8 = 1'b0;
    check("w8_busy_shift", 32'(b8), 1);
    check("w8_valid_shift", 32'(v8), 0);
    @(negedge clk);
    check("w8_lfsr", 32'(u8.u_lfsr.lfsr_q), 32'h02);
    check("w8_beat1_valid", 32'(v8), 1);
    check("w8_beat1", 32'(d8), 32'h2);
    @(negedge clk);
    check("w8_beat2_valid", 32'(v8), 1);
    check("w8_beat2", 32'(d8), 32'h0);
    check("w8_busy_beat2", 32'(b8), 1);
    @(negedge clk);
    check("w8_done_valid", 32'(v8), 0);
    check("w8_done_busy", 32'(b8), 0);
    check("w8_done_data", 32'(d8), 0);

    // default word: latency and content
    w_ref = model32(SEED32, 32);
    push_word(w_ref);
    request32(1'b0, lat);
    check("latency", lat, 33);
    collect32(-1, -1, w, nb);
    check("nbeats", nb, 4);
    check("word", w, w_ref);
    check("busy_after", 32'(b32), 0);

    // backpressure on beat 2
    w_exp = model32(w_ref, 32);
    push_word(w_exp);
    request32(1'b0, lat);
    check("latency_bp", lat, 33);
    collect32(1, -1, w, nb);
    check("nbeats_bp", nb, 4);
    check("word_bp", w, w_exp);
    check("lfsr_frozen", u32.u_lfsr.lfsr_q, w_exp);

    // seed load of zero, then seed load colliding with a request
    r_seed_in = '0; r_seed_load = 1'b1;
    @(negedge clk);
    r_seed_load = 1'b0;
    check("seed_zero", u32.u_lfsr.lfsr_q, SEED32);
    r_seed_in = 32'hDEADBEEF; r_seed_load = 1'b1; r_get = 1'b1;
    @(negedge clk);
    r_seed_load = 1'b0; r_get = 1'b0;
    check("seed_load", u32.u_lfsr.lfsr_q, 32'hDEADBEEF);
    check("seed_busy", 32'(b32), 0);
    repeat (3) @(negedge clk);
    check("seed_busy_later", 32'(b32), 0);
    check("seed_valid_later", 32'(v32), 0);

    // pulses during SHIFT and OUT are ignored
    w_exp = model32(32'hDEADBEEF, 32);
    push_word(w_exp);
    request32(1'b1, lat);
    check("latency_inj", lat, 33);
    collect32(-1, 1, w, nb);
    check("nbeats_inj", nb, 4);
    check("word_inj", w, w_exp);
    check("lfsr_inj", u32.u_lfsr.lfsr_q, w_exp);
    repeat (2) @(negedge clk);
    check("busy_inj", 32'(b32), 0);

    // reset mid-OUT after beat 1
    push_word(model32(32'hDEADBEEF, 64));
    request32(1'b0, lat);
    check("latency_rst", lat, 33);
    check("rst_beat1", 32'(d32), 32'(exp_q.pop_front()));
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_valid", 32'(v32), 0);
    check("arst_data", 32'(d32), 0);
    check("arst_busy", 32'(b32), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("arst_lfsr", u32.u_lfsr.lfsr_q, SEED32);
    push_word(w_ref);
    request32(1'b0, lat);
    check("latency_post", lat, 33);
    collect32(-1, -1, w, nb);
    check("nbeats_post", nb, 4);
    check("word_post", w, w_ref);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
